callret_monitor: RTL and testbench



---
 rtl/callret_pkg.sv | 37 +++
 rtl/callret_decode.sv | 37 +++
 rtl/callret_monitor.sv | 167 ++++++++++++++++
 tb/tb_callret_monitor.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/callret_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | callret_pkg                                                                |
// | Shared opcodes, alarm codes and enums for the call/return CFI monitor.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package callret_pkg;

  localparam logic [5:0] OPC_JAL  = 6'h01;
  localparam logic [5:0] OPC_JALR = 6'h12;
  localparam logic [5:0] OPC_JR   = 6'h11;

  localparam logic [1:0] ALM_NONE      = 2'd0;
  localparam logic [1:0] ALM_MISMATCH  = 2'd1;
  localparam logic [1:0] ALM_UNDERFLOW = 2'd2;
  localparam logic [1:0] ALM_OVERFLOW  = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUSH  = 3'd1,
    POP   = 3'd2,
    CMP   = 3'd3,
    ALARM = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CALL = 2'd1,
    RET  = 2'd2
  } insn_class_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage
`default_nettype wire

// File: rtl/callret_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | callret_decode                                                             |
// | Combinational classification of a retired word into call / return / none. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module callret_decode
  import callret_pkg::*;
#(
  parameter int unsigned LINK_REG = 9
) (
  input  logic [31:0]  insn,
  output insn_class_t  insn_class
);

  localparam logic [4:0] c_link_reg = 5'(LINK_REG);

  logic [5:0] w_opc;
  logic       w_rb_is_link;
  logic       w_unused_fields;

  assign w_opc           = opcode_of(insn);
  assign w_rb_is_link    = (insn[15:11] == c_link_reg);
  assign w_unused_fields = ^{insn[25:16], insn[10:0]};

  // Only l.jr through the link register counts as a return; other l.jr are computed jumps.
  always_comb begin
    insn_class = NONE;
    if ((w_opc == OPC_JAL) || (w_opc == OPC_JALR)) begin
      insn_class = CALL;
    end else if ((w_opc == OPC_JR) && w_rb_is_link) begin
      insn_class = RET;
    end
  end

endmodule
`default_nettype wire

// File: rtl/callret_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | callret_monitor                                                            |
// | Snoops retired calls/returns, drives the shadow return stack and raises a  |
// | sticky CFI alarm. Optional fault log: define CALLRET_FAULT_LOG_EN.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module callret_monitor
  import callret_pkg::*;
#(
  parameter logic [31:0] LINK_OFFSET = 32'd8,
  parameter int unsigned LINK_REG    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        insn_valid,
  output logic        insn_ready,
  input  logic [31:0] insn,
  input  logic [31:0] insn_pc,
  input  logic [31:0] insn_target,
  output logic        st_en,
  output logic        st_push_pop,
  output logic [31:0] st_data_in,
  input  logic [31:0] st_data_out,
  input  logic        st_empty,
  input  logic        st_violation,
  output logic        alarm,
`ifdef CALLRET_FAULT_LOG_EN
  output logic [31:0] fault_pc,
  output logic [31:0] fault_expected,
  output logic [31:0] fault_actual,
`endif
  output logic [1:0]  alarm_code
);

  state_t      r_state;
  state_t      w_next;
  insn_class_t w_class;
  logic [1:0]  w_code;
  logic        w_accept;
  logic        w_idle_accept;
  logic        w_load_link;
  logic        w_load_target;
  logic        w_enter_alarm;

  logic [31:0] r_target;
  logic [31:0] r_data_in;
  logic        r_en;
  logic        r_push_pop;
  logic        r_alarm;
  logic [1:0]  r_code;

  callret_decode #(
    .LINK_REG   (LINK_REG)
  ) u_decode (
    .insn       (insn),
    .insn_class (w_class)
  );

  assign insn_ready    = (r_state == IDLE) || (r_state == ALARM);
  assign w_accept      = insn_valid && insn_ready;
  assign w_idle_accept = w_accept && (r_state == IDLE);
  assign w_enter_alarm = (w_next == ALARM) && (r_state != ALARM);

  always_comb begin
    w_next = r_state;
    w_code = r_code;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_class == CALL) begin
            w_next = PUSH;
          end else if (w_class == RET) begin
            if (st_empty) begin
              w_next = ALARM;
              w_code = ALM_UNDERFLOW;
            end else begin
              w_next = POP;
            end
          end
        end
      end
      PUSH:  w_next = IDLE;
      POP:   w_next = CMP;
      CMP: begin
        if (st_data_out != r_target) begin
          w_next = ALARM;
          w_code = ALM_MISMATCH;
        end else begin
          w_next = IDLE;
        end
      end
      ALARM: w_next = ALARM;
      default: w_next = IDLE;
    endcase
    // Overflow pre-empts whatever was in flight and outranks the other codes.
    if ((r_state != ALARM) && st_violation) begin
      w_next = ALARM;
      w_code = ALM_OVERFLOW;
    end
  end

  assign w_load_link   = w_idle_accept && (w_next == PUSH);
  assign w_load_target = w_idle_accept && (w_next == POP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_target   <= 32'd0;
      r_data_in  <= 32'd0;
      r_en       <= 1'b0;
      r_push_pop <= 1'b0;
      r_alarm    <= 1'b0;
      r_code     <= ALM_NONE;
    end else begin
      r_state    <= w_next;
      r_en       <= (w_next == PUSH) || (w_next == POP);
      r_push_pop <= (w_next == PUSH);
      r_alarm    <= (w_next == ALARM);
      r_code     <= w_code;
      if (w_load_link) begin
        r_data_in <= insn_pc + LINK_OFFSET;
      end
      if (w_load_target) begin
        r_target <= insn_target;
      end
    end
  end

  assign st_en       = r_en;
  assign st_push_pop = r_push_pop;
  assign st_data_in  = r_data_in;
  assign alarm       = r_alarm;
  assign alarm_code  = r_code;

`ifdef CALLRET_FAULT_LOG_EN
  logic [31:0] r_last_pc;
  logic [31:0] r_fault_pc;
  logic [31:0] r_fault_expected;
  logic [31:0] r_fault_actual;

  // A return rejected in IDLE never reached r_target, so take its fields straight off the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_pc        <= 32'd0;
      r_fault_pc       <= 32'd0;
      r_fault_expected <= 32'd0;
      r_fault_actual   <= 32'd0;
    end else begin
      if (w_accept) begin
        r_last_pc <= insn_pc;
      end
      if (w_enter_alarm) begin
        r_fault_pc       <= w_idle_accept ? insn_pc : r_last_pc;
        r_fault_expected <= (w_code == ALM_MISMATCH) ? st_data_out : 32'd0;
        r_fault_actual   <= (w_idle_accept && (w_class == RET)) ? insn_target : r_target;
      end
    end
  end

  assign fault_pc       = r_fault_pc;
  assign fault_expected = r_fault_expected;
  assign fault_actual   = r_fault_actual;
`endif

endmodule
`default_nettype wire

// File: tb/tb_callret_monitor.sv
`default_nettype none
// Self-checking bench for callret_monitor: vector table, timing sequences and a
// randomized run against a transaction-level call/return model.
module tb_callret_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic [31:0] insn_target;
  logic        st_en;
  logic        st_push_pop;
  logic [31:0] st_data_in;
  logic [31:0] st_data_out;
  logic        st_empty;
  logic        st_violation;
  logic        alarm;
  logic [1:0]  alarm_code;

  always #5 clk = ~clk;

  callret_monitor #(
    .LINK_OFFSET (32'd8),
    .LINK_REG    (9)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .insn         (insn),
    .insn_pc      (insn_pc),
    .insn_target  (insn_target),
    .st_en        (st_en),
    .st_push_pop  (st_push_pop),
    .st_data_in   (st_data_in),
    .st_data_out  (st_data_out),
    .st_empty     (st_empty),
    .st_violation (st_violation),
    .alarm        (alarm),
    .alarm_code   (alarm_code)
  );

  // 128-entry shadow stack; a push into a full stack raises a sticky violation.
  logic [31:0] stk_mem [128];
  logic [7:0]  stk_sp;
  logic        stk_viol;
  logic [31:0] stk_out;
  int          push_cnt;
  int          pop_cnt;

  always @(posedge clk) begin
    if (reset) begin
      stk_sp   <= 8'd0;
      stk_viol <= 1'b0;
      stk_out  <= 32'd0;
      push_cnt <= 0;
      pop_cnt  <= 0;
    end else if (st_en) begin
      if (st_push_pop) begin
        push_cnt <= push_cnt + 1;
        if (stk_sp == 8'd128) begin
          stk_viol <= 1'b1;
        end else begin
          stk_mem[stk_sp[6:0]] <= st_data_in;
          stk_sp <= stk_sp + 8'd1;
        end
      end else begin
        pop_cnt <= pop_cnt + 1;
        if (stk_sp != 8'd0) begin
          stk_out <= stk_mem[7'(stk_sp - 8'd1)];
          stk_sp  <= stk_sp - 8'd1;
        end
      end
    end
  end

  assign st_empty     = (stk_sp == 8'd0);
  assign st_violation = stk_viol;
  assign st_data_out  = stk_out;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    insn_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!insn_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!insn_ready) check(name, 32'(insn_ready), 32'd1);
  endtask

  // Present one word for exactly one accepting cycle, then wait for the monitor to go idle.
  task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] tgt);
    wait_ready("ready_before_send");
    insn_valid  = 1'b1;
    insn        = w;
    insn_pc     = pc;
    insn_target = tgt;
    @(negedge clk);
    insn_valid = 1'b0;
    wait_ready("ready_after_send");
  endtask

  typedef struct {
    string       name;
    bit          pre_call;
    logic [31:0] call_w;
    logic [31:0] call_pc;
    logic [31:0] w;
    logic [31:0] tgt;
    logic [1:0]  exp_code;
    int          exp_push;
    int          exp_pop;
  } vec_t;

  vec_t tbl [9];

  localparam logic [31:0] JAL  = 32'h0400_0010;
  localparam logic [31:0] JALR = 32'h4800_4800;
  localparam logic [31:0] RET9 = 32'h4400_4800;
  localparam logic [31:0] JR3  = 32'h4400_1800;

  initial begin
    logic [31:0] mq [$];
    logic [31:0] w, pc, tgt, v;
    logic [1:0]  code;
    int          ep, eo, sel;
    logic [4:0]  rb;

    reset = 1'b1; insn_valid = 1'b0; insn = '0; insn_pc = '0; insn_target = '0;

    // Reset state
    do_reset();
    check("rst_ready", 32'(insn_ready), 32'd1);
    check("rst_st_en", 32'(st_en), 32'd0);
    check("rst_push_pop", 32'(st_push_pop), 32'd0);
    check("rst_data_in", st_data_in, 32'd0);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_code", 32'(alarm_code), 32'd0);

    tbl[0] = '{"jal_ret_ok",    1, JAL,  32'h100,      RET9,          32'h108,  2'd0, 1, 1};
    tbl[1] = '{"jal_ret_bad",   1, JAL,  32'h100,      RET9,          32'h200,  2'd1, 1, 1};
    tbl[2] = '{"ret_empty",     0, JAL,  32'h0,        RET9,          32'h108,  2'd2, 0, 0};
    tbl[3] = '{"jr_r3",         0, JAL,  32'h0,        JR3,           32'h108,  2'd0, 0, 0};
    tbl[4] = '{"alu_add",       0, JAL,  32'h0,        32'hE063_1800, 32'h0,    2'd0, 0, 0};
    tbl[5] = '{"jalr_wrap",     1, JALR, 32'hFFFF_FFFC, RET9,         32'h4,    2'd0, 1, 1};
    tbl[6] = '{"ret_oth_bits",  1, JAL,  32'h2000,     32'h44FF_4FFF, 32'h2008, 2'd0, 1, 1};
    tbl[7] = '{"jr3_after_jal", 1, JAL,  32'h2000,     JR3,           32'h2008, 2'd0, 1, 0};
    tbl[8] = '{"off_by_4",      1, JAL,  32'h2000,     RET9,          32'h2004, 2'd1, 1, 1};

    foreach (tbl[i]) begin
      do_reset();
      if (tbl[i].pre_call) send(tbl[i].call_w, tbl[i].call_pc, 32'h0);
      send(tbl[i].w, 32'h500, tbl[i].tgt);
      @(negedge clk);
      check({tbl[i].name, "_code"}, 32'(alarm_code), 32'(tbl[i].exp_code));
      check({tbl[i].name, "_alarm"}, 32'(alarm), 32'(tbl[i].exp_code != 2'd0));
      check({tbl[i].name, "_push"}, push_cnt, tbl[i].exp_push);
      check({tbl[i].name, "_pop"}, pop_cnt, tbl[i].exp_pop);
      if (tbl[i].pre_call) check({tbl[i].name, "_link"}, stk_mem[0], tbl[i].call_pc + 32'd8);
    end

    // Exact push/pop strobe timing for a matching pair
    do_reset();
    insn_valid = 1'b1; insn = JAL; insn_pc = 32'h100; insn_target = 32'h0;
    @(negedge clk); insn_valid = 1'b0;
    check("t_push_en", 32'(st_en), 32'd1);
    check("t_push_dir", 32'(st_push_pop), 32'd1);
    check("t_push_data", st_data_in, 32'h108);
    check("t_push_busy", 32'(insn_ready), 32'd0);
    @(negedge clk);
    check("t_push_done", 32'(st_en), 32'd0);
    check("t_push_idle", 32'(insn_ready), 32'd1);
    insn_valid = 1'b1; insn = RET9; insn_pc = 32'h500; insn_target = 32'h108;
    @(negedge clk); insn_valid = 1'b0;
    check("t_pop_en", 32'(st_en), 32'd1);
    check("t_pop_dir", 32'(st_push_pop), 32'd0);
    @(negedge clk);
    check("t_cmp_en", 32'(st_en), 32'd0);
    check("t_cmp_busy", 32'(insn_ready), 32'd0);
    @(negedge clk);
    check("t_ret_idle", 32'(insn_ready), 32'd1);
    check("t_ret_alarm", 32'(alarm), 32'd0);

    // Mismatch alarm appears exactly two cycles after the accept
    do_reset();
    send(JAL, 32'h100, 32'h0);
    insn_valid = 1'b1; insn = RET9; insn_pc = 32'h500; insn_target = 32'h200;
    @(negedge clk); insn_valid = 1'b0;
    check("mm_c1_alarm", 32'(alarm), 32'd0);
    @(negedge clk);
    check("mm_c2_alarm", 32'(alarm), 32'd0);
    @(negedge clk);
    check("mm_c3_alarm", 32'(alarm), 32'd1);
    check("mm_c3_code", 32'(alarm_code), 32'd1);
    repeat (3) @(negedge clk);
    check("mm_ready", 32'(insn_ready), 32'd1);
    send(JAL, 32'h300, 32'h0);
    check("mm_no_push", push_cnt, 1);
    check("mm_code_kept", 32'(alarm_code), 32'd1);

    // Overflow: 129 calls overrun the 128-entry stack
    do_reset();
    for (int k = 0; k < 129; k++) send(JAL, 32'h1000 + 32'(4 * k), 32'h0);
    repeat (2) @(negedge clk);
    check("ovf_viol", 32'(st_violation), 32'd1);
    check("ovf_code", 32'(alarm_code), 32'd3);
    check("ovf_alarm", 32'(alarm), 32'd1);
    check("ovf_pushes", push_cnt, 129);
    send(RET9, 32'h2000, 32'h1204);
    @(negedge clk);
    check("ovf_no_pop", pop_cnt, 0);
    check("ovf_code_kept", 32'(alarm_code), 32'd3);

    // Reset asserted while the pop strobe is out
    do_reset();
    send(JAL, 32'h100, 32'h0);
    insn_valid = 1'b1; insn = RET9; insn_pc = 32'h500; insn_target = 32'h108;
    @(negedge clk); insn_valid = 1'b0;
    check("rp_pop_en", 32'(st_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rp_en_low", 32'(st_en), 32'd0);
    check("rp_ready", 32'(insn_ready), 32'd1);
    check("rp_alarm", 32'(alarm), 32'd0);
    send(JAL, 32'h400, 32'h0);
    send(RET9, 32'h600, 32'h408);
    @(negedge clk);
    check("rp_after_code", 32'(alarm_code), 32'd0);
    check("rp_after_pop", pop_cnt, 1);

    // Randomized runs against a transaction-level return-address model
    for (int run = 0; run < 8; run++) begin
      do_reset();
      mq.delete();
      code = 2'd0; ep = 0; eo = 0;
      for (int op = 0; op < 40; op++) begin
        sel = int'($urandom_range(0, 19));
        if (sel < 8 && mq.size() < 100) begin
          pc = $urandom & 32'hFFFF_FFFC;
          w  = ($urandom_range(0, 1) == 1) ? {6'h01, 26'($urandom)} : {6'h12, 26'($urandom)};
          send(w, pc, 32'h0);
          if (code == 2'd0) begin
            mq.push_back(pc + 32'd8);
            ep++;
          end
        end else if (sel >= 8 && sel < 14 && (mq.size() > 0 || sel == 13)) begin
          if (mq.size() == 0) tgt = $urandom;
          else if (sel == 13) tgt = mq[$] ^ (32'h1 << $urandom_range(0, 31));
          else tgt = mq[$];
          w = {6'h11, 10'($urandom), 5'd9, 11'($urandom)};
          send(w, $urandom, tgt);
          if (code == 2'd0) begin
            if (mq.size() == 0) begin
              code = 2'd2;
            end else begin
              v = mq.pop_back();
              eo++;
              if (v != tgt) code = 2'd1;
            end
          end
        end else if (sel >= 14 && sel < 17) begin
          rb = 5'($urandom_range(0, 31));
          if (rb == 5'd9) rb = 5'd10;
          send({6'h11, 10'($urandom), rb, 11'($urandom)}, $urandom, $urandom);
        end else begin
          send({6'($urandom_range(32, 63)), 26'($urandom)}, $urandom, $urandom);
        end
        @(negedge clk);
        check("rand_code", 32'(alarm_code), 32'(code));
      end
      check("rand_pushes", push_cnt, ep);
      check("rand_pops", pop_cnt, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
